// File: rtl/light_timer.sv
// Seconds countdown timer with prescaler, expiry flag and end-of-run flicker.
// Optional LIGHT_TIMER_PAUSE_EN adds a t_pause input that freezes a running count.
module light_timer #(
    parameter int unsigned CLKS_PER_SEC = 100,
    parameter int unsigned FLICKER_SECS = 5,
    parameter int unsigned LEN_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_start,
    input  logic [LEN_W-1:0] t_length,
`ifdef LIGHT_TIMER_PAUSE_EN
    input  logic             t_pause,
`endif
    output logic             t_done,
    output logic             t_flicker,
    output logic [LEN_W-1:0] t_remaining
);

    localparam int unsigned PRE_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLKS_PER_SEC - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLKS_PER_SEC / 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [PRE_W-1:0] pre;
    logic [LEN_W-1:0] rem;
    logic             done_r;
    logic             hold;

`ifdef LIGHT_TIMER_PAUSE_EN
    assign hold = t_pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pre    <= '0;
            rem    <= '0;
            done_r <= 1'b0;
        end else if (t_start) begin
            rem    <= t_length;
            pre    <= '0;
            if (t_length != '0) begin
                state  <= RUN;
                done_r <= 1'b0;
            end else begin
                state  <= DONE;
                done_r <= 1'b1;
            end
        end else if (state == RUN && !hold) begin
            if (pre == PRE_MAX) begin
                pre <= '0;
                rem <= rem - LEN_W'(1);
                // last whole second has elapsed
                if (rem == LEN_W'(1)) begin
                    state  <= DONE;
                    done_r <= 1'b1;
                end
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    assign t_flicker   = (state == RUN) &&
                         (32'(rem) <= FLICKER_SECS) &&
                         (pre >= PRE_HALF);
    assign t_done      = done_r;
    assign t_remaining = rem;

endmodule

// File: tb/tb_light_timer.sv
// Randomized self-checking bench for light_timer against an elapsed-time model.
// Directed test-plan scenarios run first, then random start/length/reset traffic.
module tb_light_timer;

    localparam int C     = 4;
    localparam int F     = 2;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             t_start;
    logic [LEN_W-1:0] t_length;
    logic             t_pause;
    logic             t_done;
    logic             t_flicker;
    logic [LEN_W-1:0] t_remaining;

    int n_chk  = 0;
    int n_pass = 0;

    // model: run active, loaded length, cycles elapsed since the start edge
    bit m_act = 0;
    int m_len = 0;
    int m_e   = 0;

    always #5 clk = ~clk;

    light_timer #(
        .CLKS_PER_SEC(C),
        .FLICKER_SECS(F),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .t_start(t_start),
        .t_length(t_length),
`ifdef LIGHT_TIMER_PAUSE_EN
        .t_pause(t_pause),
`endif
        .t_done(t_done),
        .t_flicker(t_flicker),
        .t_remaining(t_remaining)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit m_done();
        return m_act && (m_e >= m_len * C);
    endfunction

    function automatic int m_rem();
        return m_act ? (m_len - m_e / C) : 0;
    endfunction

    function automatic bit m_flk();
        return m_act && (m_e < m_len * C) && (m_rem() <= F) && ((m_e % C) >= C / 2);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_act = 0;
        end else if (t_start) begin
            m_act = 1;
            m_len = int'(t_length);
            m_e   = 0;
        end else if (m_act && m_e < m_len * C) begin
`ifdef LIGHT_TIMER_PAUSE_EN
            if (!t_pause) m_e++;
`else
            m_e++;
`endif
        end
    endtask

    task automatic compare();
        chk("rem", 32'(t_remaining), 32'(m_rem()));
        chk("done", 32'(t_done), 32'(m_done()));
        chk("flicker", 32'(t_flicker), 32'(m_flk()));
    endtask

    task automatic step(input bit s, input int len, input bit p);
        t_start  = s;
        t_length = LEN_W'(len);
        t_pause  = p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // reset raised between edges: outputs must clear with no clock edge
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_rem", 32'(t_remaining), 32'd0);
        chk("async_done", 32'(t_done), 32'd0);
        chk("async_flk", 32'(t_flicker), 32'd0);
        m_act = 0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        reset = 1'b0;
    endtask

    initial begin
        int flk_cnt;
        int first_done;
        bool_block : begin end
        reset    = 1'b1;
        t_start  = 1'b0;
        t_length = '0;
        t_pause  = 1'b0;
        @(negedge clk);
        compare();
        @(negedge clk);
        reset = 1'b0;
        step(0, 7, 0);

        // basic run, length 3: flicker on 4 cycles, done from edge 12
        step(1, 3, 0);
        chk("basic_rem0", 32'(t_remaining), 32'd3);
        flk_cnt    = int'(t_flicker);
        first_done = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, $urandom_range(0, 31), 0);
            flk_cnt += int'(t_flicker);
            if (t_done && first_done < 0) first_done = i;
        end
        chk("basic_flk_cnt", 32'(flk_cnt), 32'd4);
        chk("basic_done_edge", 32'(first_done), 32'd12);

        // back-to-back restart while done is high
        step(1, 1, 0);
        chk("b2b_done_low", 32'(t_done), 32'd0);
        first_done = -1;
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0);
            if (t_done && first_done < 0) first_done = i;
        end
        chk("b2b_done_edge", 32'(first_done), 32'd4);

        // zero length
        step(1, 0, 0);
        chk("zero_done", 32'(t_done), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 9, 0);

        // restart mid-run: 5 at edge 0, 2 at edge 6, done at edge 14
        step(1, 5, 0);
        first_done = -1;
        for (int i = 1; i <= 20; i++) begin
            step(i == 6, (i == 6) ? 2 : 17, 0);
            if (i == 6) chk("restart_rem", 32'(t_remaining), 32'd2);
            if (t_done && first_done < 0) first_done = i;
        end
        chk("restart_done_edge", 32'(first_done), 32'd14);

        // reset mid-run, then a fresh run
        step(1, 3, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 4, 0);
        step(1, 3, 0);
        for (int i = 0; i < 14; i++) step(0, 2, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit s;
            int len;
            s   = ($urandom_range(0, 29) == 0);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(s, len, $urandom_range(0, 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/light_timer.md
Name: light_timer

Overview:
- Seconds-resolution countdown timer for the traffic-light controller.
- Accepts a start pulse and a 5-bit duration from the light FSM and counts the duration down in whole seconds using a clock prescaler.
- Reports expiry on t_done and drives t_flicker during the final seconds of a run, so the controller can flash green before changing light.

Parameters:
- CLKS_PER_SEC, 100, clock cycles per timer second; must be an even number, at least 2.
- FLICKER_SECS, 5, number of final seconds of a run during which t_flicker is active.
- LEN_W, 5, width of t_length and t_remaining.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- t_start  input  1  load t_length and begin counting; sampled every cycle, in every state.
- t_length  input  LEN_W  duration in seconds; sampled only when t_start=1.
- t_done  output  1  expiry flag; level signal, held until the next accepted t_start.
- t_flicker  output  1  flicker phase; 1 during the second half of each second inside the flicker window.
- t_remaining  output  LEN_W  whole seconds left in the current run.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - The prescaler counter, t_remaining, t_done and t_flicker all go to 0 immediately.
- Internal registers:
  - state: IDLE, RUN or DONE.
  - pre: prescaler count, 0..CLKS_PER_SEC-1.
  - rem: drives t_remaining.
  - done_r: drives t_done.
- t_start=1 at a clock edge, in any state (this has priority over all other transitions):
  - rem <= t_length; pre <= 0; done_r <= 0.
  - If t_length != 0, state <= RUN.
  - If t_length == 0, state <= DONE and done_r <= 1. t_done is therefore high one cycle after the start edge.
- RUN, while t_start=0:
  - pre increments each cycle.
  - When pre == CLKS_PER_SEC-1: pre <= 0 and rem <= rem-1.
  - If that decrement takes rem from 1 to 0: state <= DONE, done_r <= 1.
- Latency: for t_length = N ≥ 1, t_done rises exactly N*CLKS_PER_SEC cycles after the start edge. It is visible in the cycle following the last prescaler wrap.
- DONE:
  - pre and rem hold (rem = 0); t_done stays 1.
  - Only t_start or reset leaves DONE.
- IDLE:
  - Entered only on reset.
  - All outputs are 0; the block waits for t_start.
- Back-to-back operation: t_start in the same cycle that t_done=1 is legal. On that edge t_done clears and the new run loads, so the controller sees t_done=0 in the next cycle.
- Restart mid-run: t_start during RUN discards the current count and reloads from the new t_length. No t_done pulse is produced for the aborted run.
- t_flicker:
  - Decoded combinationally from registers only; there is no path from any input.
  - t_flicker = (state==RUN) && (rem <= FLICKER_SECS) && (pre >= CLKS_PER_SEC/2).
  - It is 0 in IDLE and DONE.
  - If t_length ≤ FLICKER_SECS, flicker applies from the first second.
- Arithmetic:
  - rem is never decremented below 0.
  - pre width is clog2(CLKS_PER_SEC).
  - t_length values up to 2^LEN_W-1 are legal; there is no saturation or clamping.
- Reset mid-run: outputs clear asynchronously. The first edge after reset deasserts honours t_start normally.

Optional Feature:
- Macro: LIGHT_TIMER_PAUSE_EN.
- Defined:
  - Adds input port t_pause (1 bit), placed after t_length.
  - While t_pause=1 in RUN, pre and rem freeze and t_flicker holds its current value.
  - t_start still overrides pause.
  - Pause has no effect in IDLE or DONE.
- Undefined: no t_pause port; counting is never suspended.

Test Plan (CLKS_PER_SEC=4, FLICKER_SECS=2):
- Basic run: t_start=1, t_length=3 at edge 0 → t_remaining reads 3, 2, 1, 0 after edges 0, 4, 8, 12; t_done=0 through edge 11 and 1 from edge 12 onward, held indefinitely.
- Flicker: same run → t_flicker=1 only after edges 6, 7, 10 and 11 (4 cycles total); 0 at all other times, including in DONE.
- Zero length: t_start with t_length=0 → t_done=1 after the next edge; t_flicker is never asserted; t_remaining=0.
- Restart: t_length=5 at edge 0, then t_length=2 at edge 6 → t_remaining=2 after edge 6; t_done rises at edge 14, with no earlier pulse.
- Back-to-back: with t_done=1, pulse t_start with t_length=1 → t_done=0 the following cycle and rises again 4 edges later.
- Reset mid-run: assert reset at edge 5 of a length-3 run → t_done, t_flicker and t_remaining go to 0 asynchronously, with no clock edge required; a later t_start behaves exactly as from power-up.
